ecdsa_lh_writer: RTL and testbench

- ECDSA-side counterpart of the logic-hash stage: consumes the lh_ecdsa_* packet/hash stream and drives the ecdsa_lh_* table-write interface.
- Captures per-packet context (fid, hash, serial number, PPL) on type1 packets and issues one verify request per packet to the signature engine.
- On a passing verdict, writes the logic-hash/serial-number/PPL table entry back through ecdsa_lh_wr; on a fail or timeout the context is discarded.
- Drives ecdsa_lh_ready as the backpressure indication to the logic-hash stage.

---
 rtl/ecdsa_lh_writer_pkg.sv | 48 ++++
 rtl/ecdsa_lh_writer_sfifo2f1.sv | 60 ++++++
 rtl/ecdsa_lh_writer.sv | 193 +++++++++++++++++++
 tb/tb_ecdsa_lh_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_lh_writer_pkg.sv
// Shared widths, header field positions and context types for the ECDSA-side
// logic-hash table writer.
package ecdsa_lh_writer_pkg;

  localparam int LOGIC_HASH_NBITS = 32;
  localparam int DATA_PATH_NBITS  = 64;
  localparam int FID_NBITS        = 8;
  localparam int SERIAL_NUM_NBITS = 16;
  localparam int PPL_NBITS        = 4;
  localparam int PKT_LEN_NBITS    = 8;

  // Header bit positions (MSB of each field) of the serial number and PPL.
  localparam int SERIAL_NUM_POS   = 63;
  localparam int PPL_POS          = 47;

  typedef struct packed {
    logic [FID_NBITS-1:0]     fid;
    logic [PKT_LEN_NBITS-1:0] pkt_len;
  } lh_ecdsa_meta_type;

  typedef struct packed {
    logic [FID_NBITS-1:0]        fid;
    logic [LOGIC_HASH_NBITS-1:0] hash;
    logic [SERIAL_NUM_NBITS-1:0] sn;
    logic [PPL_NBITS-1:0]        ppl;
  } ecdsa_ctx_type;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } wr_state_e;

  function automatic ecdsa_ctx_type build_ctx(
    input lh_ecdsa_meta_type           meta,
    input logic [LOGIC_HASH_NBITS-1:0] hash,
    input logic [DATA_PATH_NBITS-1:0]  hdr
  );
    ecdsa_ctx_type ctx;
    ctx.fid  = meta.fid;
    ctx.hash = hash;
    ctx.sn   = hdr[SERIAL_NUM_POS -: SERIAL_NUM_NBITS];
    ctx.ppl  = hdr[PPL_POS -: PPL_NBITS];
    return ctx;
  endfunction

endpackage

// File: rtl/ecdsa_lh_writer_sfifo2f1.sv
// Synchronous single-clock FIFO; push to a full FIFO and pop from an empty
// FIFO are ignored. count_next exposes the occupancy after the current cycle.
module sfifo2f1 #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_NBITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_NBITS:0]   count_next
);

  localparam int DEPTH   = 1 << DEPTH_NBITS;
  localparam int CNT_W   = DEPTH_NBITS + 1;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_NBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_NBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_ok;
  logic                   pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? wr_ptr_q + DEPTH_NBITS'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + DEPTH_NBITS'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  assign count_next = count_d;
  assign dout       = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ecdsa_lh_writer.sv
// Captures per-packet context from the logic-hash stream, asks the signature
// engine to verify it, and writes verified entries back to the logic-hash table.
module ecdsa_lh_writer
  import ecdsa_lh_writer_pkg::*;
#(
  parameter int CTX_DEPTH_NBITS = 2,
  parameter int VRFY_TIMEOUT    = 1023,
  parameter int STAT_NBITS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        lh_ecdsa_hash_valid,
  input  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data,
  input  logic                        lh_ecdsa_valid,
  input  logic [DATA_PATH_NBITS-1:0]  lh_ecdsa_hdr_data,
  input  lh_ecdsa_meta_type           lh_ecdsa_meta_data,
  input  logic                        lh_ecdsa_sop,
  input  logic                        lh_ecdsa_eop,
  output logic                        ecdsa_lh_ready,
  output logic                        vrfy_req_valid,
  input  logic                        vrfy_req_ready,
  output logic [FID_NBITS-1:0]        vrfy_req_fid,
  output logic [LOGIC_HASH_NBITS-1:0] vrfy_req_hash,
  input  logic                        vrfy_rsp_valid,
  input  logic                        vrfy_rsp_pass,
  output logic                        ecdsa_lh_wr,
  output logic [FID_NBITS-1:0]        ecdsa_lh_waddr,
  output logic [LOGIC_HASH_NBITS-1:0] ecdsa_lh_wdata,
  output logic [SERIAL_NUM_NBITS-1:0] ecdsa_lh_sn_wdata,
  output logic [PPL_NBITS-1:0]        ecdsa_lh_ppl_wdata,
  output logic [STAT_NBITS-1:0]       stat_pass_cnt,
  output logic [STAT_NBITS-1:0]       stat_fail_cnt,
  output logic [STAT_NBITS-1:0]       stat_drop_cnt
);

  localparam int CNT_NBITS = CTX_DEPTH_NBITS + 1;
  localparam int TMR_NBITS = $clog2(VRFY_TIMEOUT + 1);
  localparam logic [CNT_NBITS-1:0] READY_MAX = CNT_NBITS'((1 << CTX_DEPTH_NBITS) - 2);
  localparam logic [TMR_NBITS-1:0] TMR_MAX   = TMR_NBITS'(VRFY_TIMEOUT);

  wr_state_e                   state_q, state_d;
  logic [TMR_NBITS-1:0]        timer_q, timer_d;
  logic                        ready_q, ready_d;
  logic                        wr_q, wr_d;
  logic [FID_NBITS-1:0]        waddr_q, waddr_d;
  logic [LOGIC_HASH_NBITS-1:0] wdata_q, wdata_d;
  logic [SERIAL_NUM_NBITS-1:0] sn_q, sn_d;
  logic [PPL_NBITS-1:0]        ppl_q, ppl_d;
  logic [STAT_NBITS-1:0]       pass_cnt_q, pass_cnt_d;
  logic [STAT_NBITS-1:0]       fail_cnt_q, fail_cnt_d;
  logic [STAT_NBITS-1:0]       drop_cnt_q, drop_cnt_d;

  ecdsa_ctx_type               push_ctx;
  ecdsa_ctx_type               head_ctx;
  logic                        push_req;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [CNT_NBITS-1:0]        fifo_count_next;
  logic                        capture_drop;
  logic                        timeout_drop;
  logic                        pass_evt;
  logic                        fail_evt;
  logic                        unused_bits;

  function automatic logic [STAT_NBITS-1:0] sat_add(
    input logic [STAT_NBITS-1:0] cnt,
    input logic [1:0]            inc
  );
    logic [STAT_NBITS:0] sum;
    sum = {1'b0, cnt} + (STAT_NBITS+1)'(inc);
    return sum[STAT_NBITS] ? '1 : sum[STAT_NBITS-1:0];
  endfunction

  // Only the first beat of a type1 packet carries context; later beats only frame.
  always_comb begin
    push_ctx     = build_ctx(lh_ecdsa_meta_data, lh_ecdsa_hash_data, lh_ecdsa_hdr_data);
    push_req     = lh_ecdsa_valid & lh_ecdsa_sop & lh_ecdsa_hash_valid;
    fifo_push    = push_req & ~fifo_full;
    capture_drop = (lh_ecdsa_valid & lh_ecdsa_sop & ~lh_ecdsa_hash_valid) |
                   (push_req & fifo_full);
  end

  assign unused_bits = ^{lh_ecdsa_eop, lh_ecdsa_hdr_data, lh_ecdsa_meta_data};

  sfifo2f1 #(
    .WIDTH      ($bits(ecdsa_ctx_type)),
    .DEPTH_NBITS(CTX_DEPTH_NBITS)
  ) u_ctx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .din       (push_ctx),
    .pop       (fifo_pop),
    .dout      (head_ctx),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count_next(fifo_count_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (vrfy_req_ready) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (vrfy_rsp_valid && vrfy_rsp_pass) begin
          state_d = ST_WRITE;
        end else if (vrfy_rsp_valid || (timer_q == TMR_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_NBITS'(1);
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request fields are gated so nothing from stale FIFO storage leaks out.
  always_comb begin
    vrfy_req_valid = (state_q == ST_REQ);
    vrfy_req_fid   = vrfy_req_valid ? head_ctx.fid  : '0;
    vrfy_req_hash  = vrfy_req_valid ? head_ctx.hash : '0;
    pass_evt       = (state_q == ST_WRITE);
    fail_evt       = (state_q == ST_WAIT) & vrfy_rsp_valid & ~vrfy_rsp_pass;
    timeout_drop   = (state_q == ST_WAIT) & ~vrfy_rsp_valid & (timer_q == TMR_MAX);
    fifo_pop       = pass_evt | fail_evt | timeout_drop;
    wr_d           = (state_q == ST_WAIT) & vrfy_rsp_valid & vrfy_rsp_pass;
    waddr_d        = wr_d ? head_ctx.fid  : '0;
    wdata_d        = wr_d ? head_ctx.hash : '0;
    sn_d           = wr_d ? head_ctx.sn   : '0;
    ppl_d          = wr_d ? head_ctx.ppl  : '0;
    ready_d        = (fifo_count_next <= READY_MAX);
    pass_cnt_d     = sat_add(pass_cnt_q, {1'b0, pass_evt});
    fail_cnt_d     = sat_add(fail_cnt_q, {1'b0, fail_evt});
    drop_cnt_d     = sat_add(drop_cnt_q, 2'(capture_drop) + 2'(timeout_drop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      sn_q       <= '0;
      ppl_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      sn_q       <= sn_d;
      ppl_q      <= ppl_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ecdsa_lh_ready     = ready_q;
  assign ecdsa_lh_wr        = wr_q;
  assign ecdsa_lh_waddr     = waddr_q;
  assign ecdsa_lh_wdata     = wdata_q;
  assign ecdsa_lh_sn_wdata  = sn_q;
  assign ecdsa_lh_ppl_wdata = ppl_q;
  assign stat_pass_cnt      = pass_cnt_q;
  assign stat_fail_cnt      = fail_cnt_q;
  assign stat_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_ecdsa_lh_writer.sv
// Directed, scoreboard-checked bench for ecdsa_lh_writer: capture, verify
// handshake, table write, overflow, timeout and mid-operation reset.
module tb_ecdsa_lh_writer;
  import ecdsa_lh_writer_pkg::*;

  localparam int STAT_NBITS   = 16;
  localparam int VRFY_TIMEOUT = 1023;
  localparam int CTX_DEPTH    = 4;

  typedef struct packed {
    logic [FID_NBITS-1:0]        fid;
    logic [LOGIC_HASH_NBITS-1:0] hash;
    logic [SERIAL_NUM_NBITS-1:0] sn;
    logic [PPL_NBITS-1:0]        ppl;
  } exp_ctx_t;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        lh_ecdsa_hash_valid = 1'b0;
  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data = '0;
  logic                        lh_ecdsa_valid = 1'b0;
  logic [DATA_PATH_NBITS-1:0]  lh_ecdsa_hdr_data = '0;
  lh_ecdsa_meta_type           lh_ecdsa_meta_data = '0;
  logic                        lh_ecdsa_sop = 1'b0;
  logic                        lh_ecdsa_eop = 1'b0;
  logic                        ecdsa_lh_ready;
  logic                        vrfy_req_valid;
  logic                        vrfy_req_ready = 1'b0;
  logic [FID_NBITS-1:0]        vrfy_req_fid;
  logic [LOGIC_HASH_NBITS-1:0] vrfy_req_hash;
  logic                        vrfy_rsp_valid = 1'b0;
  logic                        vrfy_rsp_pass = 1'b0;
  logic                        ecdsa_lh_wr;
  logic [FID_NBITS-1:0]        ecdsa_lh_waddr;
  logic [LOGIC_HASH_NBITS-1:0] ecdsa_lh_wdata;
  logic [SERIAL_NUM_NBITS-1:0] ecdsa_lh_sn_wdata;
  logic [PPL_NBITS-1:0]        ecdsa_lh_ppl_wdata;
  logic [STAT_NBITS-1:0]       stat_pass_cnt;
  logic [STAT_NBITS-1:0]       stat_fail_cnt;
  logic [STAT_NBITS-1:0]       stat_drop_cnt;

  exp_ctx_t ctx_q[$];
  int       n_cmp = 0;
  int       n_err = 0;
  int       exp_pass = 0;
  int       exp_fail = 0;
  int       exp_drop = 0;

  ecdsa_lh_writer #(
    .CTX_DEPTH_NBITS(2),
    .VRFY_TIMEOUT   (VRFY_TIMEOUT),
    .STAT_NBITS     (STAT_NBITS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lh_ecdsa_hash_valid(lh_ecdsa_hash_valid),
    .lh_ecdsa_hash_data (lh_ecdsa_hash_data),
    .lh_ecdsa_valid     (lh_ecdsa_valid),
    .lh_ecdsa_hdr_data  (lh_ecdsa_hdr_data),
    .lh_ecdsa_meta_data (lh_ecdsa_meta_data),
    .lh_ecdsa_sop       (lh_ecdsa_sop),
    .lh_ecdsa_eop       (lh_ecdsa_eop),
    .ecdsa_lh_ready     (ecdsa_lh_ready),
    .vrfy_req_valid     (vrfy_req_valid),
    .vrfy_req_ready     (vrfy_req_ready),
    .vrfy_req_fid       (vrfy_req_fid),
    .vrfy_req_hash      (vrfy_req_hash),
    .vrfy_rsp_valid     (vrfy_rsp_valid),
    .vrfy_rsp_pass      (vrfy_rsp_pass),
    .ecdsa_lh_wr        (ecdsa_lh_wr),
    .ecdsa_lh_waddr     (ecdsa_lh_waddr),
    .ecdsa_lh_wdata     (ecdsa_lh_wdata),
    .ecdsa_lh_sn_wdata  (ecdsa_lh_sn_wdata),
    .ecdsa_lh_ppl_wdata (ecdsa_lh_ppl_wdata),
    .stat_pass_cnt      (stat_pass_cnt),
    .stat_fail_cnt      (stat_fail_cnt),
    .stat_drop_cnt      (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_pass_cnt"}, 64'(stat_pass_cnt), 64'(exp_pass));
    checkOutput({tag, "_fail_cnt"}, 64'(stat_fail_cnt), 64'(exp_fail));
    checkOutput({tag, "_drop_cnt"}, 64'(stat_drop_cnt), 64'(exp_drop));
  endtask

  // Drives one beat for one cycle and records what the DUT should capture.
  task automatic applyStimulus(input logic [FID_NBITS-1:0] fid,
                               input logic [LOGIC_HASH_NBITS-1:0] hash,
                               input logic [SERIAL_NUM_NBITS-1:0] sn,
                               input logic [PPL_NBITS-1:0] ppl,
                               input logic valid, input logic sop,
                               input logic eop, input logic hash_valid);
    logic [DATA_PATH_NBITS-1:0] hdr;
    exp_ctx_t c;
    hdr = DATA_PATH_NBITS'({$urandom, $urandom});
    hdr[SERIAL_NUM_POS -: SERIAL_NUM_NBITS] = sn;
    hdr[PPL_POS -: PPL_NBITS] = ppl;
    lh_ecdsa_valid          = valid;
    lh_ecdsa_sop            = sop;
    lh_ecdsa_eop            = eop;
    lh_ecdsa_hash_valid     = hash_valid;
    lh_ecdsa_hash_data      = hash;
    lh_ecdsa_hdr_data       = hdr;
    lh_ecdsa_meta_data.fid  = fid;
    lh_ecdsa_meta_data.pkt_len = 8'(($urandom % 200) + 1);
    c.fid = fid; c.hash = hash; c.sn = sn; c.ppl = ppl;
    if (valid && sop) begin
      if (!hash_valid || ctx_q.size() >= CTX_DEPTH) exp_drop++;
      else ctx_q.push_back(c);
    end
    tick();
    lh_ecdsa_valid      = 1'b0;
    lh_ecdsa_sop        = 1'b0;
    lh_ecdsa_eop        = 1'b0;
    lh_ecdsa_hash_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, checks it against the scoreboard head and
  // lets the handshake edge pass (vrfy_req_ready must already be 1).
  task automatic waitReq(input string tag);
    int n = 0;
    while (vrfy_req_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req_seen"}, 64'(vrfy_req_valid), 64'(1));
    if (ctx_q.size() != 0) begin
      checkOutput({tag, "_req_fid"},  64'(vrfy_req_fid),  64'(ctx_q[0].fid));
      checkOutput({tag, "_req_hash"}, 64'(vrfy_req_hash), 64'(ctx_q[0].hash));
    end
    tick();
  endtask

  task automatic respond(input string tag, input logic pass, input int delay);
    repeat (delay) tick();
    vrfy_rsp_valid = 1'b1;
    vrfy_rsp_pass  = pass;
    tick();
    vrfy_rsp_valid = 1'b0;
    vrfy_rsp_pass  = 1'b0;
    if (pass) begin
      checkOutput({tag, "_wr"}, 64'(ecdsa_lh_wr), 64'(1));
      if (ctx_q.size() != 0) begin
        checkOutput({tag, "_waddr"}, 64'(ecdsa_lh_waddr),     64'(ctx_q[0].fid));
        checkOutput({tag, "_wdata"}, 64'(ecdsa_lh_wdata),     64'(ctx_q[0].hash));
        checkOutput({tag, "_sn"},    64'(ecdsa_lh_sn_wdata),  64'(ctx_q[0].sn));
        checkOutput({tag, "_ppl"},   64'(ecdsa_lh_ppl_wdata), 64'(ctx_q[0].ppl));
      end
      tick();
      checkOutput({tag, "_wr_one_cycle"}, 64'(ecdsa_lh_wr), 64'(0));
      exp_pass++;
    end else begin
      checkOutput({tag, "_no_wr"}, 64'(ecdsa_lh_wr), 64'(0));
      exp_fail++;
    end
    if (ctx_q.size() != 0) void'(ctx_q.pop_front());
  endtask

  initial begin
    int wr_seen;
    int req_seen;

    // Reset state
    tick(); tick();
    checkOutput("rst_ready",     64'(ecdsa_lh_ready), 64'(0));
    checkOutput("rst_req_valid", 64'(vrfy_req_valid), 64'(0));
    checkOutput("rst_wr",        64'(ecdsa_lh_wr),    64'(0));
    checkCounters("rst");
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", 64'(ecdsa_lh_ready), 64'(1));

    // Single passing packet with latency checks
    $display("[TB] single pass packet");
    vrfy_req_ready = 1'b1;
    applyStimulus(8'd5, 32'hA5A5_1234, 16'd7, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("lat_req_n1", 64'(vrfy_req_valid), 64'(0));
    tick();
    checkOutput("lat_req_n2", 64'(vrfy_req_valid), 64'(1));
    waitReq("p1");
    respond("p1", 1'b1, 10);
    checkCounters("p1");

    // Fail verdict, then the queued packet is requested
    $display("[TB] fail verdict");
    applyStimulus(8'd9,  32'hDEAD_0009, 16'h0109, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'd10, 32'hBEEF_0010, 16'h0110, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    waitReq("f9");
    respond("f9", 1'b0, 3);
    checkCounters("f9");
    waitReq("f10");
    respond("f10", 1'b1, 2);
    checkCounters("f10");

    // Overflow with the verifier stalled
    $display("[TB] overflow");
    vrfy_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(20 + i), 32'h1000_0000 + 32'(i), 16'(100 + i), 4'(i + 4),
                    1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("ovf_ready_%0d", i), 64'(ecdsa_lh_ready),
                  64'(ctx_q.size() <= CTX_DEPTH - 2));
    end
    checkCounters("ovf");
    vrfy_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitReq($sformatf("ovf_drain_%0d", i));
      respond($sformatf("ovf_drain_%0d", i), 1'b1, 1);
    end
    checkCounters("ovf_drain");

    // Type2 packet, eop-only beat and sop without hash
    $display("[TB] ignored and dropped beats");
    applyStimulus(8'd30, 32'h2222_2222, 16'd1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'd31, 32'h3333_3333, 16'd2, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (vrfy_req_valid === 1'b1) req_seen++;
      tick();
    end
    checkOutput("type2_no_req", 64'(req_seen), 64'(0));
    applyStimulus(8'd32, 32'h4444_4444, 16'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkCounters("nohash");

    // Verify timeout boundary and a late response
    $display("[TB] timeout");
    applyStimulus(8'd40, 32'h5555_0040, 16'd40, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    waitReq("tmo");
    repeat (VRFY_TIMEOUT) tick();
    checkOutput("tmo_before", 64'(stat_drop_cnt), 64'(exp_drop));
    tick();
    exp_drop++;
    if (ctx_q.size() != 0) void'(ctx_q.pop_front());
    checkCounters("tmo_after");
    vrfy_rsp_valid = 1'b1;
    vrfy_rsp_pass  = 1'b1;
    tick();
    vrfy_rsp_valid = 1'b0;
    vrfy_rsp_pass  = 1'b0;
    checkOutput("late_rsp_no_wr", 64'(ecdsa_lh_wr), 64'(0));
    tick();
    checkCounters("late_rsp");

    // Reset while waiting on a verdict with two contexts queued
    $display("[TB] reset mid-operation");
    applyStimulus(8'd50, 32'h6666_0050, 16'd50, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'd51, 32'h6666_0051, 16'd51, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    waitReq("mid");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    ctx_q.delete();
    exp_pass = 0; exp_fail = 0; exp_drop = 0;
    checkOutput("mid_rst_ready", 64'(ecdsa_lh_ready), 64'(0));
    checkOutput("mid_rst_req",   64'(vrfy_req_valid), 64'(0));
    checkOutput("mid_rst_wr",    64'(ecdsa_lh_wr),    64'(0));
    checkCounters("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rel_ready", 64'(ecdsa_lh_ready), 64'(1));
    wr_seen = 0;
    req_seen = 0;
    for (int i = 0; i < 30; i++) begin
      vrfy_rsp_valid = (i == 5);
      vrfy_rsp_pass  = (i == 5);
      if (ecdsa_lh_wr === 1'b1) wr_seen++;
      if (vrfy_req_valid === 1'b1) req_seen++;
      tick();
    end
    vrfy_rsp_valid = 1'b0;
    vrfy_rsp_pass  = 1'b0;
    checkOutput("mid_no_wr",  64'(wr_seen),  64'(0));
    checkOutput("mid_no_req", 64'(req_seen), 64'(0));
    checkCounters("mid_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
